// File: rtl/mtr_drv_pkg.sv
// Shared constants for the dual H-bridge motor driver.
package mtr_drv_pkg;

  localparam int unsigned PWM_W   = 11;
  localparam int unsigned DEAD    = 32;
  localparam int unsigned BLANK   = 64;
  localparam int unsigned OVR_MAX = 4;

  localparam int unsigned BLANK_W = $clog2(BLANK + 1);
  localparam int unsigned OVR_W   = $clog2(OVR_MAX + 1);

  typedef logic [PWM_W-1:0] duty_t;

  localparam duty_t PRD_LAST = PWM_W'(2**PWM_W - 1);

endpackage

// File: rtl/mtr_side.sv
// One wheel: shadowed duty/direction, dead-time, steering and overcurrent supervision.
module mtr_side
  import mtr_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt,
  input  logic             prd_last,
  input  logic [PWM_W-1:0] spd,
  input  logic             rev,
  input  logic             ovr_i,
  input  logic             fault,
  output logic             fwd_pwm,
  output logic             rev_pwm,
  output logic             fault_req
);

  localparam logic [PWM_W-1:0]   DEAD_C  = PWM_W'(DEAD);
  localparam logic [BLANK_W-1:0] BLANK_C = BLANK_W'(BLANK);
  localparam logic [OVR_W-1:0]   OVR_C   = OVR_W'(OVR_MAX);
  localparam logic [OVR_W-1:0]   OVR_PRE = OVR_W'(OVR_MAX - 1);

  logic [PWM_W-1:0]   shd_spd;
  logic               shd_rev;
  logic               prev_rev;
  logic [1:0]         ovr_sync;
  logic [BLANK_W-1:0] blank_cnt;
  logic               hit;
  logic [OVR_W-1:0]   ovr_cnt;

  logic rev_chg;
  logic on;
  logic sample_ok;
  logic hit_now;

  always_comb begin
    rev_chg   = (shd_rev != prev_rev);
    on        = (cnt < shd_spd) && !(rev_chg && (cnt < DEAD_C));
    sample_ok = on && (blank_cnt >= BLANK_C);
    hit_now   = hit || (sample_ok && ovr_sync[1]);
    // Request on the same edge the period counter reaches OVR_MAX so the latch lands with it.
    fault_req = prd_last && hit_now && (ovr_cnt >= OVR_PRE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shd_spd   <= '0;
      shd_rev   <= 1'b0;
      prev_rev  <= 1'b0;
      ovr_sync  <= '0;
      blank_cnt <= '0;
      hit       <= 1'b0;
      ovr_cnt   <= '0;
      fwd_pwm   <= 1'b0;
      rev_pwm   <= 1'b0;
    end else begin
      ovr_sync <= {ovr_sync[0], ovr_i};

      if (!on)
        blank_cnt <= '0;
      else if (blank_cnt != BLANK_C)
        blank_cnt <= blank_cnt + 1'b1;

      if (prd_last) begin
        shd_spd  <= spd;
        shd_rev  <= rev;
        prev_rev <= shd_rev;
        hit      <= 1'b0;
        if (!hit_now)
          ovr_cnt <= '0;
        else if (ovr_cnt != OVR_C)
          ovr_cnt <= ovr_cnt + 1'b1;
      end else begin
        hit <= hit_now;
      end

      fwd_pwm <= on && !shd_rev && !fault;
      rev_pwm <= on &&  shd_rev && !fault;
    end
  end

endmodule

// File: rtl/mtr_drv.sv
// Dual H-bridge driver: shared PWM timebase, per-wheel drive and a sticky overcurrent shutdown.
module mtr_drv
  import mtr_drv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PWM_W-1:0]  lft_spd,
  input  logic              lft_rev,
  input  logic [PWM_W-1:0]  rght_spd,
  input  logic              rght_rev,
  input  logic              ovr_i_lft,
  input  logic              ovr_i_rght,
  output logic              lft_fwd_pwm,
  output logic              lft_rev_pwm,
  output logic              rght_fwd_pwm,
  output logic              rght_rev_pwm,
  output logic              prd_strt,
  output logic              fault
);

  logic [PWM_W-1:0] cnt;
  logic             prd_last;
  logic             req_lft;
  logic             req_rght;

  assign prd_last = (cnt == PRD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      prd_strt <= 1'b0;
      fault    <= 1'b0;
    end else begin
      cnt      <= cnt + 1'b1;
      prd_strt <= prd_last;
      fault    <= fault || req_lft || req_rght;
    end
  end

  mtr_side u_lft (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .prd_last  (prd_last),
    .spd       (lft_spd),
    .rev       (lft_rev),
    .ovr_i     (ovr_i_lft),
    .fault     (fault),
    .fwd_pwm   (lft_fwd_pwm),
    .rev_pwm   (lft_rev_pwm),
    .fault_req (req_lft)
  );

  mtr_side u_rght (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (cnt),
    .prd_last  (prd_last),
    .spd       (rght_spd),
    .rev       (rght_rev),
    .ovr_i     (ovr_i_rght),
    .fault     (fault),
    .fwd_pwm   (rght_fwd_pwm),
    .rev_pwm   (rght_rev_pwm),
    .fault_req (req_rght)
  );

endmodule
